vedic_mul16_seq_ctrl: RTL and testbench

//  Sequencing controller that computes an unsigned 16x16 -> 32-bit product.
//  It time-multiplexes one internally instantiated vedic_8X8 multiplier over

---
 rtl/vedic_mul16_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vedic_mul16_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul16_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : vedic_8X8 / vedic_mul16_seq_ctrl                           |
// | Description : Area-lean unsigned 16x16->32 multiplier. One 8x8 Vedic    |
// |               multiplier is reused over four partial products that are  |
// |               summed into a 32-bit accumulator.                         |
// | Ports (top) : clk, rst (sync, active-high)                              |
// |               in_valid/in_ready/in_a[15:0]/in_b[15:0]  operand handshake|
// |               out_valid/out_ready/out_p[31:0]          product handshake|
// |               busy                                      not IDLE        |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------

// 8x8 unsigned multiplier, Urdhva-Tiryagbhyam split into four 4x4 crosswise
// products: p = ll + (lh + hl) << 4 + hh << 8.
module vedic_8X8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   logic [7:0] w_ll;
   logic [7:0] w_lh;
   logic [7:0] w_hl;
   logic [7:0] w_hh;
   logic [8:0] w_mid;

   // Operands are zero-extended so each partial product keeps all 8 bits.
   assign w_ll  = {4'b0, a[3:0]} * {4'b0, b[3:0]};
   assign w_lh  = {4'b0, a[3:0]} * {4'b0, b[7:4]};
   assign w_hl  = {4'b0, a[7:4]} * {4'b0, b[3:0]};
   assign w_hh  = {4'b0, a[7:4]} * {4'b0, b[7:4]};
   assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
   assign p     = {8'b0, w_ll} + {3'b0, w_mid, 4'b0} + {w_hh, 8'b0};
endmodule

module vedic_mul16_seq_ctrl #(
   parameter int unsigned PIPE_MUL = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_p,
   output logic        busy
);
   localparam logic [1:0] c_s_idle  = 2'd0;
   localparam logic [1:0] c_s_mul   = 2'd1;
   localparam logic [1:0] c_s_drain = 2'd2;
   localparam logic [1:0] c_s_done  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   logic [1:0]  r_step;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [31:0] r_acc;
   logic [31:0] r_p;

   logic [7:0]  w_mul_a;
   logic [7:0]  w_mul_b;
   logic [15:0] w_prod;
   logic [15:0] w_add_prod;
   logic [1:0]  w_add_step;
   logic        w_acc_en;
   logic [31:0] w_term;
   logic [31:0] w_acc_next;

   // Step selects which byte of each operand feeds the shared multiplier.
   assign w_mul_a = r_step[0] ? r_a[15:8] : r_a[7:0];
   assign w_mul_b = r_step[1] ? r_b[15:8] : r_b[7:0];

   vedic_8X8 u_mul (
      .a (w_mul_a),
      .b (w_mul_b),
      .p (w_prod)
   );

   generate
      if (PIPE_MUL != 0) begin : g_pipe
         // Registered product plus the step it belongs to; accumulation
         // trails the multiply by one edge, DRAIN absorbs the last one.
         logic [15:0] r_pprod;
         logic [1:0]  r_pstep;
         logic        r_pv;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_pprod <= 16'd0;
               r_pstep <= 2'd0;
               r_pv    <= 1'b0;
            end else begin
               r_pprod <= w_prod;
               r_pstep <= r_step;
               r_pv    <= (r_state == c_s_mul);
            end
         end

         assign w_add_prod = r_pprod;
         assign w_add_step = r_pstep;
         assign w_acc_en   = r_pv;
      end else begin : g_comb
         assign w_add_prod = w_prod;
         assign w_add_step = r_step;
         assign w_acc_en   = (r_state == c_s_mul);
      end
   endgenerate

   always_comb begin
      w_term = {16'b0, w_add_prod};
      case (w_add_step)
         2'd1, 2'd2: w_term = {8'b0, w_add_prod, 8'b0};
         2'd3:       w_term = {w_add_prod, 16'b0};
         default:    w_term = {16'b0, w_add_prod};
      endcase
   end

   // Partial sums top out at 0xFFFE0001, so 32 bits never carry out.
   assign w_acc_next = w_acc_en ? (r_acc + w_term) : r_acc;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_s_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_s_idle:  if (in_valid) w_state_next = c_s_mul;
         c_s_mul:   if (r_step == 2'd3)
                       w_state_next = (PIPE_MUL != 0) ? c_s_drain : c_s_done;
         c_s_drain: w_state_next = c_s_done;
         c_s_done:  if (out_ready) w_state_next = c_s_idle;
         default:   w_state_next = c_s_idle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (r_state == c_s_idle);
      out_valid = (r_state == c_s_done);
      busy      = (r_state != c_s_idle);
   end

   assign out_p = r_p;

   // Datapath. out_p has its own register so it holds the last product
   // while the accumulator is cleared and reused for the next operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a    <= 16'd0;
         r_b    <= 16'd0;
         r_acc  <= 32'd0;
         r_step <= 2'd0;
         r_p    <= 32'd0;
      end else begin
         if ((r_state == c_s_idle) && in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_acc  <= 32'd0;
            r_step <= 2'd0;
         end else begin
            r_acc <= w_acc_next;
            if (r_state == c_s_mul) begin
               r_step <= r_step + 2'd1;
            end
         end
         if ((r_state != c_s_done) && (w_state_next == c_s_done)) begin
            r_p <= w_acc_next;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_vedic_mul16_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_vedic_mul16_seq_ctrl                                    |
// | Description : Directed self-checking bench for vedic_mul16_seq_ctrl,    |
// |               one instance per PIPE_MUL setting.                        |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module tb_vedic_mul16_seq_ctrl;
   logic        clk;
   logic        rst;
   logic        iv0, ir0, ov0, or0, busy0;
   logic [15:0] a0, b0;
   logic [31:0] p0;
   logic        iv1, ir1, ov1, or1, busy1;
   logic [15:0] a1, b1;
   logic [31:0] p1;

   int vectors;
   int miscompares;

   vedic_mul16_seq_ctrl #(.PIPE_MUL(0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
      .out_valid(ov0), .out_ready(or0), .out_p(p0), .busy(busy0)
   );

   vedic_mul16_seq_ctrl #(.PIPE_MUL(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
      .out_valid(ov1), .out_ready(or1), .out_p(p1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operand pair for a single edge; called right after a negedge.
   task automatic do_accept(input bit pipe, input logic [15:0] a, input logic [15:0] b);
      if (pipe) begin iv1 = 1'b1; a1 = a; b1 = b; end
      else      begin iv0 = 1'b1; a0 = a; b0 = b; end
      @(negedge clk);
      iv0 = 1'b0;
      iv1 = 1'b0;
   endtask

   // Edges counted from acceptance until out_valid is seen; -1 if never.
   task automatic wait_valid(input bit pipe, output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if ((pipe ? ov1 : ov0) === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic release0;
      or0 = 1'b1;
      @(negedge clk);
      or0 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (ir0 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready0: got %b expected 1", ir0); end
      vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid0: got %b expected 0", ov0); end
      vectors++; if (p0 !== 32'h0) begin miscompares++; $display("FAIL reset_out_p0: got %h expected 00000000", p0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
      vectors++; if (ir1 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready1: got %b expected 1", ir1); end
      vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
   endtask

   task automatic test_basic;
      int lat;
      do_accept(0, 16'h1234, 16'h5678);
      vectors++; if (ir0 !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_low: got %b expected 0", ir0); end
      wait_valid(0, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      vectors++; if (p0 !== 32'h06260060) begin miscompares++; $display("FAIL basic_product: got %h expected 06260060", p0); end
      vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_done: got %b expected 1", busy0); end
      release0();
      vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL basic_out_valid_drop: got %b expected 0", ov0); end
      vectors++; if (ir0 !== 1'b1) begin miscompares++; $display("FAIL basic_back_idle: got %b expected 1", ir0); end
      vectors++; if (p0 !== 32'h06260060) begin miscompares++; $display("FAIL basic_out_p_hold: got %h expected 06260060", p0); end
   endtask

   task automatic test_max;
      int lat;
      do_accept(0, 16'hFFFF, 16'hFFFF);
      wait_valid(0, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL max_latency: got %0d expected 4", lat); end
      vectors++; if (p0 !== 32'hFFFE0001) begin miscompares++; $display("FAIL max_product: got %h expected fffe0001", p0); end
      release0();
   endtask

   task automatic test_backpressure;
      int lat;
      do_accept(0, 16'h00AB, 16'h0100);
      wait_valid(0, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL bp_latency: got %0d expected 4", lat); end
      for (int i = 0; i < 10; i++) begin
         iv0 = i[0];
         a0  = 16'h1111 + 16'(i);
         b0  = 16'h2222;
         @(negedge clk);
         vectors++; if (ov0 !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, ov0); end
         vectors++; if (p0 !== 32'h0000AB00) begin miscompares++; $display("FAIL bp_out_p[%0d]: got %h expected 0000ab00", i, p0); end
         vectors++; if (ir0 !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, ir0); end
      end
      iv0 = 1'b0;
      release0();
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after: got %b expected 0", busy0); end
      vectors++; if (p0 !== 32'h0000AB00) begin miscompares++; $display("FAIL bp_out_p_after: got %h expected 0000ab00", p0); end
      do_accept(0, 16'h0002, 16'h0003);
      wait_valid(0, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
      vectors++; if (p0 !== 32'h00000006) begin miscompares++; $display("FAIL bp_next_product: got %h expected 00000006", p0); end
      release0();
   endtask

   task automatic test_reset_mid;
      int lat;
      do_accept(0, 16'h1111, 16'h2222);
      @(negedge clk);
      @(negedge clk);
      // Now in MUL step 2.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (ir0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b expected 1", ir0); end
      vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid: got %b expected 0", ov0); end
      vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
      vectors++; if (p0 !== 32'h0) begin miscompares++; $display("FAIL rstmid_out_p: got %h expected 00000000", p0); end
      do_accept(0, 16'h0003, 16'h0005);
      wait_valid(0, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
      vectors++; if (p0 !== 32'h0000000F) begin miscompares++; $display("FAIL rstmid_product: got %h expected 0000000f", p0); end
      release0();
   endtask

   task automatic test_back_to_back;
      int          nhigh, npulse, t1, t2;
      logic [31:0] v1, v2;
      logic        prev, idle_after;
      nhigh = 0; npulse = 0; t1 = -1; t2 = -1;
      v1 = 32'hDEADBEEF; v2 = 32'hDEADBEEF;
      prev = 1'b0; idle_after = 1'b0;
      or0 = 1'b1;
      iv0 = 1'b1; a0 = 16'h0001; b0 = 16'h0000;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         if (npulse == 1 && t == t1 + 1) idle_after = (ir0 === 1'b1) && (busy0 === 1'b0);
         if (ov0 === 1'b1) begin
            nhigh++;
            if (!prev) begin
               npulse++;
               if (npulse == 1) begin
                  t1 = t; v1 = p0;
                  a0 = 16'h8000; b0 = 16'h0002;
               end else if (npulse == 2) begin
                  t2 = t; v2 = p0;
                  iv0 = 1'b0;
               end
            end
         end
         prev = ov0;
      end
      iv0 = 1'b0;
      or0 = 1'b0;
      vectors++; if (nhigh !== 2) begin miscompares++; $display("FAIL b2b_valid_cycles: got %0d expected 2", nhigh); end
      vectors++; if (t1 !== 5) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 5", t1); end
      vectors++; if (t2 - t1 !== 6) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 6", t2 - t1); end
      vectors++; if (v1 !== 32'h0) begin miscompares++; $display("FAIL b2b_product1: got %h expected 00000000", v1); end
      vectors++; if (v2 !== 32'h00010000) begin miscompares++; $display("FAIL b2b_product2: got %h expected 00010000", v2); end
      vectors++; if (idle_after !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_after_handshake: got %b expected 1", idle_after); end
   endtask

   task automatic test_pipe;
      int lat, nb;
      lat = -1; nb = 0;
      vectors++; if (ir1 !== 1'b1) begin miscompares++; $display("FAIL pipe_in_ready: got %b expected 1", ir1); end
      do_accept(1, 16'h00FF, 16'hFF00);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ov1 === 1'b1) begin
            lat = k;
            break;
         end
         if (busy1 === 1'b1) nb++;
      end
      vectors++; if (lat !== 5) begin miscompares++; $display("FAIL pipe_latency: got %0d expected 5", lat); end
      vectors++; if (nb !== 4) begin miscompares++; $display("FAIL pipe_busy_cycles: got %0d expected 4", nb); end
      vectors++; if (p1 !== 32'h00FE0100) begin miscompares++; $display("FAIL pipe_product: got %h expected 00fe0100", p1); end
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
      vectors++; if (ov1 !== 1'b0) begin miscompares++; $display("FAIL pipe_out_valid_drop: got %b expected 0", ov1); end
      vectors++; if (p1 !== 32'h00FE0100) begin miscompares++; $display("FAIL pipe_out_p_hold: got %h expected 00fe0100", p1); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      iv0 = 1'b0; a0 = 16'h0; b0 = 16'h0; or0 = 1'b0;
      iv1 = 1'b0; a1 = 16'h0; b1 = 16'h0; or1 = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_pipe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
